// File: rtl/game_pkg.sv
// game_pkg: shared player/state/column types and a lowest-free-column helper
// for the turn scheduler.
package game_pkg;
  localparam int NUM_COLS = 7;
  typedef enum logic {P1 = 1'b0, P2 = 1'b1} player_t;
  typedef enum logic [2:0] {IDLE, WAIT_MOVE, ISSUE, LOCKOUT, DONE} sched_state_t;
  typedef logic [2:0] col_t;
  function automatic col_t first_free(input logic [7:0] full);
    first_free = '0;
    for (int i = 7; i >= 0; i--) if (!full[i]) first_free = col_t'(i);
  endfunction
endpackage

// File: rtl/cycle_timer.sv
// cycle_timer: clearable, enabled up-counter that holds at its terminal count.
module cycle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] tc,
  output logic         hit
);
  logic [W-1:0] cnt;
  assign hit = cnt == tc;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && !hit) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/turn_scheduler.sv
// turn_scheduler: turn-based disc insert sequencer with post-insert lockout.
// Define TURN_TIMEOUT_EN to force a move after TURN_TIMEOUT_CYCLES idle cycles.
module turn_scheduler
  import game_pkg::*;
#(
  parameter int LOCKOUT_CYCLES      = 12_500_000,
  parameter int TURN_TIMEOUT_CYCLES = 250_000_000,
  parameter int COLS                = NUM_COLS
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            game_over,
  input  logic            p1_req,
  input  logic [2:0]      p1_col,
  input  logic            p2_req,
  input  logic [2:0]      p2_col,
  input  logic [COLS-1:0] col_full,
  output logic            ins_valid,
  input  logic            ins_ready,
  output logic [2:0]      ins_col,
  output logic            ins_player,
  output logic            cur_player,
  output logic            enabled,
  output logic            reject,
  output logic            timeout
);
  localparam int MAX_CYC = LOCKOUT_CYCLES > TURN_TIMEOUT_CYCLES ? LOCKOUT_CYCLES : TURN_TIMEOUT_CYCLES;
  localparam int W = $clog2(MAX_CYC + 1);
  sched_state_t state;
  player_t cur;
  logic [7:0] full;
  logic req, legal, hit, clr, cnt_en, tmo_hit;
  col_t col;
  // Columns beyond COLS read as full, so one lookup covers range and occupancy.
  always_comb begin
    full = '1;
    full[COLS-1:0] = col_full;
  end
  assign req = cur == P2 ? p2_req : p1_req;
  assign col = cur == P2 ? p2_col : p1_col;
  assign legal = req && !full[col];
  assign cur_player = cur;
`ifdef TURN_TIMEOUT_EN
  assign cnt_en = state == WAIT_MOVE || state == LOCKOUT;
  assign tmo_hit = state == WAIT_MOVE && hit;
`else
  assign cnt_en = state == LOCKOUT;
  assign tmo_hit = 1'b0;
`endif
  assign clr = start || !(state == WAIT_MOVE || state == LOCKOUT) || (state == LOCKOUT && hit);
  cycle_timer #(.W(W)) u_timer (
    .clk,
    .reset,
    .clr,
    .en(cnt_en),
    .tc(state == LOCKOUT ? W'(LOCKOUT_CYCLES - 1) : W'(TURN_TIMEOUT_CYCLES - 1)),
    .hit
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cur        <= P1;
      ins_col    <= '0;
      ins_player <= 1'b0;
      ins_valid  <= 1'b0;
      enabled    <= 1'b0;
      reject     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      reject  <= 1'b0;
      timeout <= 1'b0;
      if (start && state != ISSUE) begin
        state     <= WAIT_MOVE;
        cur       <= P1;
        enabled   <= 1'b1;
        ins_valid <= 1'b0;
      end else begin
        case (state)
          WAIT_MOVE: begin
            if (game_over || (tmo_hit && !legal && &full)) begin
              state   <= DONE;
              enabled <= 1'b0;
            end else if (legal || tmo_hit) begin
              state      <= ISSUE;
              enabled    <= 1'b0;
              ins_valid  <= 1'b1;
              ins_col    <= legal ? col : first_free(full);
              ins_player <= cur;
              timeout    <= !legal;
            end else reject <= req;
          end
          ISSUE: if (ins_ready) begin
            state     <= LOCKOUT;
            ins_valid <= 1'b0;
          end
          LOCKOUT: if (hit) begin
            state   <= game_over ? DONE : WAIT_MOVE;
            enabled <= !game_over;
            if (!game_over) cur <= cur == P1 ? P2 : P1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_turn_scheduler.sv
// tb_turn_scheduler: directed table-driven checks of turn_scheduler
// (LOCKOUT_CYCLES=4, TURN_TIMEOUT_CYCLES=20, COLS=7).
module tb_turn_scheduler;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, game_over = 1'b0;
  logic p1_req = 1'b0, p2_req = 1'b0, ins_ready = 1'b0;
  logic [2:0] p1_col = '0, p2_col = '0;
  logic [6:0] col_full = '0;
  logic ins_valid, ins_player, cur_player, enabled, reject, timeout;
  logic [2:0] ins_col;
  int applied = 0, miscompares = 0;
  typedef struct {
    logic st, go, r1;
    logic [2:0] c1;
    logic r2;
    logic [2:0] c2;
    logic [6:0] full;
    logic rdy;
    logic [8:0] exp;
  } vec_t;
  vec_t tbl[$];
  always #5 clk = ~clk;
  turn_scheduler #(.LOCKOUT_CYCLES(4), .TURN_TIMEOUT_CYCLES(20), .COLS(7)) dut (
    .clk(clk), .reset(reset), .start(start), .game_over(game_over),
    .p1_req(p1_req), .p1_col(p1_col), .p2_req(p2_req), .p2_col(p2_col),
    .col_full(col_full), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .ins_col(ins_col), .ins_player(ins_player), .cur_player(cur_player),
    .enabled(enabled), .reject(reject), .timeout(timeout)
  );
  // Expected output bundle: {ins_valid, ins_col, ins_player, cur_player, enabled, reject, timeout}
  function automatic logic [8:0] o(input logic v, input logic [2:0] col, input logic pl,
                                   input logic cur, input logic en, input logic rej, input logic to);
    return {v, col, pl, cur, en, rej, to};
  endfunction
  function automatic vec_t vv(input logic st, input logic go, input logic r1, input logic [2:0] c1,
                              input logic r2, input logic [2:0] c2, input logic [6:0] full,
                              input logic rdy, input logic [8:0] exp);
    vec_t t;
    t.st = st; t.go = go; t.r1 = r1; t.c1 = c1; t.r2 = r2; t.c2 = c2;
    t.full = full; t.rdy = rdy; t.exp = exp;
    return t;
  endfunction
  // ins_col/ins_player are only meaningful while ins_valid is expected high.
  task automatic chk(input string nm, input logic [8:0] exp);
    logic [8:0] act, m;
    act = {ins_valid, ins_col, ins_player, cur_player, enabled, reject, timeout};
    m = exp[8] ? 9'h1ff : 9'h10f;
    applied++;
    if ((act & m) !== (exp & m)) begin
      miscompares++;
      $display("FAIL %s: got v/col/pl/cur/en/rej/to=%b required %b (mask %b)", nm, act, exp, m);
    end
  endtask
  task automatic chk_zero(input string nm);
    logic [8:0] act;
    act = {ins_valid, ins_col, ins_player, cur_player, enabled, reject, timeout};
    applied++;
    if (act !== 9'h0) begin
      miscompares++;
      $display("FAIL %s: got outputs %b required all zero", nm, act);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    start = 0; game_over = 0; p1_req = 0; p2_req = 0; ins_ready = 0;
    p1_col = 0; p2_col = 0;
  endtask
  initial begin
    tbl.push_back(vv(1,0,0,0,0,0,7'h00,0, o(0,0,0,0,1,0,0)));
    tbl.push_back(vv(0,0,1,3,0,0,7'h00,0, o(1,3,0,0,0,0,0)));
    tbl.push_back(vv(0,0,0,0,0,0,7'h00,1, o(0,0,0,0,0,0,0)));
    tbl.push_back(vv(0,0,1,0,1,4,7'h00,0, o(0,0,0,0,0,0,0)));
    tbl.push_back(vv(0,0,0,0,0,0,7'h00,0, o(0,0,0,0,0,0,0)));
    tbl.push_back(vv(0,0,0,0,0,0,7'h00,0, o(0,0,0,0,0,0,0)));
    tbl.push_back(vv(0,0,0,0,0,0,7'h00,0, o(0,0,0,1,1,0,0)));
    tbl.push_back(vv(0,0,0,0,1,6,7'h00,0, o(1,6,1,1,0,0,0)));
    tbl.push_back(vv(0,0,0,0,0,0,7'h00,1, o(0,0,0,1,0,0,0)));
    tbl.push_back(vv(0,0,0,0,0,0,7'h00,0, o(0,0,0,1,0,0,0)));
    tbl.push_back(vv(0,0,0,0,0,0,7'h00,0, o(0,0,0,1,0,0,0)));
    tbl.push_back(vv(0,0,0,0,0,0,7'h00,0, o(0,0,0,1,0,0,0)));
    tbl.push_back(vv(0,0,0,0,0,0,7'h00,0, o(0,0,0,0,1,0,0)));
    tbl.push_back(vv(0,0,1,5,1,2,7'h00,0, o(1,5,0,0,0,0,0)));
    tbl.push_back(vv(0,0,0,0,0,0,7'h00,1, o(0,0,0,0,0,0,0)));
    tbl.push_back(vv(0,0,0,0,0,0,7'h00,0, o(0,0,0,0,0,0,0)));
    tbl.push_back(vv(0,0,0,0,0,0,7'h00,0, o(0,0,0,0,0,0,0)));
    tbl.push_back(vv(0,0,0,0,0,0,7'h00,0, o(0,0,0,0,0,0,0)));
    tbl.push_back(vv(0,0,0,0,0,0,7'h00,0, o(0,0,0,1,1,0,0)));
    tbl.push_back(vv(0,0,0,0,1,7,7'h00,0, o(0,0,0,1,1,1,0)));
    tbl.push_back(vv(0,0,0,0,1,1,7'h02,0, o(0,0,0,1,1,1,0)));
    tbl.push_back(vv(0,0,0,0,0,0,7'h02,0, o(0,0,0,1,1,0,0)));
    tbl.push_back(vv(0,0,1,0,0,0,7'h02,0, o(0,0,0,1,1,0,0)));
    tbl.push_back(vv(0,0,0,0,1,0,7'h02,0, o(1,0,1,1,0,0,0)));
    #12;
    chk_zero("reset_state");
    #2 reset = 1;
    foreach (tbl[i]) begin
      start = tbl[i].st; game_over = tbl[i].go;
      p1_req = tbl[i].r1; p1_col = tbl[i].c1;
      p2_req = tbl[i].r2; p2_col = tbl[i].c2;
      col_full = tbl[i].full; ins_ready = tbl[i].rdy;
      step();
      chk($sformatf("vec%0d", i), tbl[i].exp);
    end
    idle();
    col_full = 7'h00;
    // ISSUE stalled by ins_ready with game_over toggling: command must hold.
    for (int i = 0; i < 10; i++) begin
      game_over = i[0];
      start = (i == 4);
      step();
      chk($sformatf("stall%0d", i), o(1,0,1,1,0,0,0));
    end
    start = 0; game_over = 1; ins_ready = 1;
    step(); chk("stall_hs", o(0,0,0,1,0,0,0));
    ins_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step(); chk($sformatf("lock_go%0d", i), o(0,0,0,1,0,0,0));
    end
    step(); chk("done_after_lock", o(0,0,0,1,0,0,0));
    p2_req = 1; p2_col = 3; p1_req = 1; p1_col = 3;
    step(); chk("done_ignores_req", o(0,0,0,1,0,0,0));
    idle(); start = 1;
    step(); chk("restart_from_done", o(0,0,0,0,1,0,0));
    idle();
`ifdef TURN_TIMEOUT_EN
    col_full = 7'h03;
    for (int i = 0; i < 19; i++) begin
      step(); chk($sformatf("to_idle%0d", i), o(0,0,0,0,1,0,0));
    end
    step(); chk("to_forced", o(1,2,0,0,0,0,1));
    ins_ready = 1;
    step(); chk("to_hs", o(0,0,0,0,0,0,0));
    ins_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step(); chk($sformatf("to_lock%0d", i), o(0,0,0,0,0,0,0));
    end
    step(); chk("to_p2_turn", o(0,0,0,1,1,0,0));
    col_full = 7'h7f;
    for (int i = 0; i < 19; i++) begin
      step(); chk($sformatf("full_idle%0d", i), o(0,0,0,1,1,0,0));
    end
    step(); chk("full_done", o(0,0,0,1,0,0,0));
    col_full = 7'h00;
`else
    for (int i = 0; i < 25; i++) begin
      step(); chk($sformatf("no_timer%0d", i), o(0,0,0,0,1,0,0));
    end
`endif
    start = 1;
    step(); chk("rst_seq_start", o(0,0,0,0,1,0,0));
    start = 0; p1_req = 1; p1_col = 4;
    step(); chk("rst_seq_issue", o(1,4,0,0,0,0,0));
    p1_req = 0; ins_ready = 1;
    step(); chk("rst_seq_lock0", o(0,0,0,0,0,0,0));
    ins_ready = 0;
    step(); chk("rst_seq_lock1", o(0,0,0,0,0,0,0));
    reset = 0;
    #2 chk_zero("async_reset");
    #3 reset = 1;
    p1_req = 1; p1_col = 1;
    step(); chk_zero("idle_after_reset0");
    step(); chk_zero("idle_after_reset1");
    idle(); start = 1;
    step(); chk("start_after_reset", o(0,0,0,0,1,0,0));
    idle();
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
